// File: rtl/spi_master_arb_pkg.sv
// Shared definitions for the SPI master with round-robin arbitration:
// FSM state encoding, default parameter values and a counter-width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_e;

    localparam int DEF_BITS     = 8;
    localparam int DEF_NREQ     = 2;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_IDLE_GAP = 2;

    // Number of bits needed to hold the values 0..n-1 (never less than one).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_master_arb_rr_arbiter.sv
// Combinational round-robin picker: searches upward from the requester after
// ptr_i (wrapping) and returns the first active request as one-hot + index.
// The pointer register itself lives in the parent.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    // First requester after the pointer wins; nothing is granted when disabled.
    always_comb begin
        int c;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        c       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            c = int'(ptr_i) + k;
            c = (c >= NREQ) ? (c - NREQ) : c;
            if (en_i && !valid_o && req_i[c]) begin
                valid_o  = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/spi_master_arb.sv
// SPI mode-0 master shared between NREQ requesters by round-robin arbitration.
// Optional build macro SPI_MASTER_LOOPBACK_EN: when defined, the receive path
// samples the internal mosi instead of the miso pin.
import spi_pkg::*;

module spi_master_arb #(
    parameter int BITS     = DEF_BITS,
    parameter int NREQ     = DEF_NREQ,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int IDLE_GAP = DEF_IDLE_GAP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BITS-1:0] txData,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 done,
    output logic [BITS-1:0]      rxData,
    output logic                 sclk,
    output logic [NREQ-1:0]      ss_n,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int BW = cnt_width(BITS + 1);
    localparam int DW = cnt_width(CLK_DIV);
    localparam int GW = cnt_width(IDLE_GAP);
    localparam int IW = cnt_width(NREQ);

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [BITS-1:0] tx_q, tx_d;
    logic [BITS-1:0] rx_q, rx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ss_n_q, ss_n_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BITS-1:0] rxdata_q, rxdata_d;

    logic            tick_s;
    logic            rx_bit_s;
    logic            arb_en_s;
    logic [NREQ-1:0] arb_gnt_s;
    logic [IW-1:0]   arb_idx_s;
    logic            arb_valid_s;
    logic [BITS-1:0] tx_slice_s;

    assign tick_s     = (div_q == DW'(CLK_DIV - 1));
    assign arb_en_s   = (state_q == IDLE);
    assign tx_slice_s = txData[int'(arb_idx_s)*BITS +: BITS];

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_bit_s = mosi_q;
`else
    assign rx_bit_s = miso;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .en_i    (arb_en_s),
        .gnt_o   (arb_gnt_s),
        .idx_o   (arb_idx_s),
        .valid_o (arb_valid_s)
    );

    // Next-state and datapath: grant, shift out MSB first, sample on rising sclk.
    always_comb begin
        state_d  = state_q;
        div_d    = tick_s ? '0 : (div_q + DW'(1));
        gap_d    = gap_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        ss_n_d   = ss_n_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rxdata_d = rxdata_q;
        case (state_q)
            IDLE: begin
                div_d = '0;
                if (arb_valid_s) begin
                    state_d = SETUP;
                    grant_d = arb_gnt_s;
                    ss_n_d  = ~arb_gnt_s;
                    gidx_d  = arb_idx_s;
                    tx_d    = tx_slice_s;
                    mosi_d  = tx_slice_s[BITS-1];
                    rx_d    = '0;
                    bit_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                // First tick is also the first rising edge, so it samples.
                if (tick_s) begin
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[BITS-2:0], rx_bit_s};
                    bit_d   = bit_q + BW'(1);
                    state_d = XFER;
                end else begin
                    state_d = SETUP;
                end
            end
            XFER: begin
                if (tick_s && !sclk_q) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[BITS-2:0], rx_bit_s};
                    bit_d  = bit_q + BW'(1);
                end else if (tick_s) begin
                    sclk_d = 1'b0;
                    if (bit_q == BW'(BITS)) begin
                        state_d = HOLD;
                    end else begin
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[BITS-2];
                    end
                end else begin
                    state_d = XFER;
                end
            end
            HOLD: begin
                // One extra half-period keeps ss_n low after the last falling edge.
                if (tick_s) begin
                    ss_n_d   = '1;
                    mosi_d   = 1'b0;
                    rxdata_d = rx_q;
                    done_d   = 1'b1;
                    grant_d  = '0;
                    ptr_d    = gidx_q;
                    gap_d    = '0;
                    state_d  = GAP;
                end else begin
                    state_d = HOLD;
                end
            end
            GAP: begin
                if (gap_q == GW'(IDLE_GAP - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                // Unreachable encoding: release the bus and return to idle.
                state_d = IDLE;
                grant_d = '0;
                ss_n_d  = '1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            gap_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            ptr_q    <= IW'(NREQ - 1);
            gidx_q   <= '0;
            grant_q  <= '0;
            ss_n_q   <= '1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rxdata_q <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            gap_q    <= gap_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            ss_n_q   <= ss_n_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rxdata_q <= rxdata_d;
        end
    end

    assign grant  = grant_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign rxData = rxdata_q;
    assign sclk   = sclk_q;
    assign ss_n   = ss_n_q;
    assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_master_arb.sv
// Bench for spi_master_arb with default parameters (BITS=8, NREQ=2,
// CLK_DIV=2, IDLE_GAP=2) and a behavioural mode-0 SPI slave.
module tb_spi_master_arb;

    localparam int BITS     = 8;
    localparam int NREQ     = 2;
    localparam int CLK_DIV  = 2;
    localparam int IDLE_GAP = 2;
    localparam int XFER_CYC = CLK_DIV * (2 * BITS + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*BITS-1:0] txData = '0;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 done;
    logic [BITS-1:0]      rxData;
    logic                 sclk;
    logic [NREQ-1:0]      ss_n;
    logic                 mosi;
    logic                 miso;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mptr  = NREQ - 1;
    int done_cnt = 0;
    int rise_cnt = 0;
    int viol  = 0;

    spi_master_arb #(
        .BITS(BITS), .NREQ(NREQ), .CLK_DIV(CLK_DIV), .IDLE_GAP(IDLE_GAP)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .txData(txData), .grant(grant),
        .busy(busy), .done(done), .rxData(rxData), .sclk(sclk), .ss_n(ss_n),
        .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    // Cycle counter and event counters.
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;
    always @(posedge sclk) rise_cnt <= rise_cnt + 1;

    // Behavioural mode-0 slave: loads on select, samples on rise, shifts on fall.
    logic [BITS-1:0] slv_pre = '0;
    logic [BITS-1:0] slv_sr  = '0;
    logic [BITS-1:0] slv_rx  = '0;
    logic            any_sel;
    assign any_sel = ~&ss_n;
    assign miso    = slv_sr[BITS-1];
    always @(posedge any_sel) begin slv_sr = slv_pre; slv_rx = '0; end
    always @(posedge sclk) if (any_sel) slv_rx = {slv_rx[BITS-2:0], mosi};
    always @(negedge sclk) if (any_sel) slv_sr = {slv_sr[BITS-2:0], 1'b0};

    // Bus invariants sampled mid-cycle.
    logic [NREQ-1:0] prev_ss = '1;
    logic            prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if ($countones(~ss_n) > 1) viol++;
            if (sclk && (&ss_n)) viol++;
            if ((~ss_n & ~grant) != '0) viol++;
            if ((ss_n != prev_ss) && prev_sclk) viol++;
        end
        prev_ss   = ss_n;
        prev_sclk = sclk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    // Reference round robin: first requester after the last granted index.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [BITS-1:0] exp_rx(input logic [BITS-1:0] tx, input logic [BITS-1:0] pre);
`ifdef SPI_MASTER_LOOPBACK_EN
        return tx;
`else
        return pre;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        mptr = NREQ - 1;
    endtask

    // One transfer: request, check grant/timing/data against the model.
    task automatic run_one(input logic [NREQ-1:0] rq, input logic [BITS-1:0] t0,
                           input logic [BITS-1:0] t1, input logic [BITS-1:0] pre,
                           input bit drop_req, input bit chk_gap, input int gap_ref,
                           output logic [NREQ-1:0] g_seen, output int dcyc);
        int eg, n, gcyc;
        logic [BITS-1:0] words [NREQ];
        logic [BITS-1:0] sent;
        logic [NREQ-1:0] egnt, ess;
        logic [31:0] rnd;
        words[0] = t0;
        words[1] = t1;
        slv_pre  = pre;
        txData   = {t1, t0};
        req      = rq;
        eg   = rr_pick(rq, mptr);
        egnt = (eg >= 0) ? NREQ'(1 << eg) : '0;
        sent = (eg >= 0) ? words[eg] : '0;
        n = 0;
        while (grant == '0 && n < 100) begin @(negedge clk); n++; end
        g_seen = grant;
        check("grant", grant, egnt);
        if (chk_gap) check("gap_to_grant", cyc - gap_ref, IDLE_GAP + 1);
        ess = ~egnt;
        check("ss_n_sel", ss_n, ess);
        check("busy_on", busy, 1);
        gcyc = cyc;
        if (drop_req) req = '0;
        rnd = $urandom();
        txData = rnd[NREQ*BITS-1:0];
        n = 0;
        while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("done_latency", cyc - gcyc, XFER_CYC);
        check("rxData", rxData, exp_rx(sent, pre));
        check("slave_rx", slv_rx, sent);
        check("grant_clear", grant, 0);
        check("ss_n_idle", ss_n, {NREQ{1'b1}});
        if (eg >= 0) mptr = eg;
        dcyc = cyc;
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic [BITS-1:0] tx0, tx1, pre;
        logic [NREQ-1:0] egnt;
        logic [BITS-1:0] erx, erx_lb;
    } vec_t;

    vec_t vt [6];

    initial begin
        logic [NREQ-1:0] gs;
        logic [NREQ-1:0] seq_exp [4];
        logic [31:0] rnd;
        int dref, d0, r0, n;

        vt[0] = '{2'b01, 8'hC5, 8'h00, 8'h65, 2'b01, 8'h65, 8'hC5};
        vt[1] = '{2'b11, 8'h11, 8'h22, 8'h3C, 2'b10, 8'h3C, 8'h22};
        vt[2] = '{2'b11, 8'h5A, 8'hA5, 8'h81, 2'b01, 8'h81, 8'h5A};
        vt[3] = '{2'b10, 8'h00, 8'hFF, 8'h00, 2'b10, 8'h00, 8'hFF};
        vt[4] = '{2'b10, 8'h00, 8'h01, 8'h7E, 2'b10, 8'h7E, 8'h01};
        vt[5] = '{2'b11, 8'h80, 8'h00, 8'hFE, 2'b01, 8'hFE, 8'h80};
        seq_exp[0] = 2'b01; seq_exp[1] = 2'b10; seq_exp[2] = 2'b01; seq_exp[3] = 2'b10;

        // Reset state.
        do_reset();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rxData", rxData, 0);
        check("rst_sclk", sclk, 0);
        check("rst_ss_n", ss_n, 2'b11);
        check("rst_mosi", mosi, 0);

        // Table-driven transfers, back to back from reset.
        dref = 0;
        for (int i = 0; i < 6; i++) begin
            run_one(vt[i].req, vt[i].tx0, vt[i].tx1, vt[i].pre, 1'b0, i > 0, dref, gs, dref);
            check("tbl_grant", gs, vt[i].egnt);
`ifdef SPI_MASTER_LOOPBACK_EN
            check("tbl_rx", rxData, vt[i].erx_lb);
`else
            check("tbl_rx", rxData, vt[i].erx);
`endif
        end

        // Randomized transfers against the model, txData scrambled after grant.
        for (int i = 0; i < 20; i++) begin
            logic [NREQ-1:0] rq;
            rnd = $urandom();
            rq  = NREQ'($urandom_range(1, 3));
            run_one(rq, rnd[7:0], rnd[15:8], rnd[23:16], rnd[24], 1'b1, dref, gs, dref);
        end
        req = '0;
        repeat (5) @(negedge clk);

        // Both requesting, held: 01,10,01,10 with exact gaps.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_one(2'b11, 8'hC3 + 8'(i), 8'h3C - 8'(i), 8'h96 ^ 8'(i), 1'b0, i > 0, dref, gs, dref);
            check("hold_seq", gs, seq_exp[i]);
        end
        req = '0;
        repeat (5) @(negedge clk);

        // Single-cycle request pulse: exactly one transfer.
        do_reset();
        d0 = done_cnt;
        slv_pre = 8'h5A;
        txData  = 16'h003C;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        check("pulse_grant", grant, 2'b01);
        n = 0;
        while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("pulse_rx", rxData, exp_rx(8'h3C, 8'h5A));
        repeat (40) @(negedge clk);
        check("pulse_done_once", done_cnt - d0, 1);
        check("pulse_idle_busy", busy, 0);
        check("pulse_idle_grant", grant, 0);

        // Reset after the 4th rising sclk: bus dropped, no done, rxData cleared.
        slv_pre = 8'hA5;
        txData  = 16'h0077;
        r0 = rise_cnt;
        req = 2'b01;
        n = 0;
        while ((rise_cnt - r0) < 4 && n < 200) begin @(negedge clk); n++; end
        check("mid_rises", rise_cnt - r0, 4);
        d0  = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("mid_ss_n", ss_n, 2'b11);
        check("mid_sclk", sclk, 0);
        check("mid_busy", busy, 0);
        check("mid_rxData", rxData, 0);
        check("mid_grant", grant, 0);
        check("mid_done", done, 0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_no_done", done_cnt - d0, 0);

        check("bus_invariants", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_arb.md
Name: spi_master_arb

Overview:
- System-clocked SPI mode-0 master that owns one SPI bus and shares it between NREQ requesters, each with its own slave select.
- Round-robin arbitration picks one requester, latches its transmit word, and generates sclk, mosi and the selected ss_n line for one BITS-bit transfer.
- Returns the received word with a one-cycle done pulse.
- Sits between on-chip agents and the off-chip or on-chip SPI slaves (e.g. SPI_SLAVE).

Parameters:
- BITS, 8, word length per transfer (>=2).
- NREQ, 2, number of requesters/slave selects (>=1).
- CLK_DIV, 2, clk cycles per sclk half-period (>=1).
- IDLE_GAP, 2, clk cycles ss_n stays all-high between transfers (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester transfer request, level.
- txData  in  NREQ*BITS  transmit words; slice i belongs to requester i; sampled only at grant.
- grant  out  NREQ  one-hot owner of the current transfer; zero when idle.
- busy  out  1  high from grant through the end of GAP.
- done  out  1  one-cycle pulse; rxData is valid from this cycle.
- rxData  out  BITS  last received word; holds until the next done.
- sclk  out  1  SPI clock, idle low.
- ss_n  out  NREQ  active-low selects; at most one low at a time.
- mosi  out  1  master out, MSB first.
- miso  in  1  master in.

Behaviour:
- Reset values: grant=0, busy=0, done=0, rxData=0, sclk=0, ss_n=all 1, mosi=0. Round-robin pointer=NREQ-1, so req[0] has first priority.
- Reset mid-transfer: the bus is abandoned on the same edge. No done pulse is issued and rxData is cleared.
- IDLE state:
  - If any req bit is high at edge E, the arbiter grants the first requester after the last-granted index, with wrap-around.
  - At E: grant[g]=1, ss_n[g]=0, tx shift register=txData slice g, mosi=bit BITS-1, busy=1, bit counter=0. Go to SETUP.
- Divider: a counter counts CLK_DIV clk cycles. Each terminal count is a "tick". The counter reloads on every state entry.
- SETUP: the first tick raises sclk (E+CLK_DIV). Go to XFER.
- XFER, on each tick:
  - If sclk was low, raise it. Sample miso into the rx shift register LSB (shifting left) and increment the bit counter.
  - If sclk was high, lower it. If bit counter==BITS, go to HOLD. Otherwise shift tx and drive the next bit on mosi.
  - Rising edges occur at E+CLK_DIV*(1+2k) and falling edges at E+CLK_DIV*(2+2k), for k=0..BITS-1.
- HOLD: on the tick at E+CLK_DIV*(2*BITS+1):
  - ss_n all high, mosi=0, rxData=rx shift register, done=1 for one cycle.
  - grant=0, pointer=g. Go to GAP.
- GAP: lasts IDLE_GAP cycles (busy=1), then IDLE.
  - A pending req is granted exactly IDLE_GAP+1 cycles after done.
- Dropping req after grant does not abort the transfer: it completes and done pulses.
- Changing txData after grant has no effect on the current transfer.
- Simultaneous requests: exactly one is granted, per round robin. A requester holding req continuously cannot starve others.
- ss_n changes only while sclk=0. sclk never toggles while ss_n is all high.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- Defined: the miso port is ignored and the rx path samples the internal mosi instead, so rxData equals the transmitted word. Bus outputs still toggle normally.
- Undefined: miso is used as specified.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, SETUP, XFER, HOLD, GAP);
  - default constants for BITS, CLK_DIV and IDLE_GAP;
  - a counter-width helper function (clog2 of BITS+1 and of CLK_DIV).
- Sub-module rr_arbiter (NREQ):
  - inputs req, a pointer and an enable;
  - outputs a one-hot grant and its index;
  - purely combinational next-grant logic, with the pointer register kept in the parent.

Test Plan:
- Reset, then req=2'b01 with txData[7:0]=8'hC5; a SPI_SLAVE model preloaded with 8'h65 (BITS=8, CLK_DIV=2) -> ss_n=2'b10; the slave receives C5; done at E+34; rxData=8'h65; grant=2'b01 until done.
- req=2'b11 asserted together after reset -> requester 0 served first, then grant=2'b10 exactly IDLE_GAP+1=3 cycles after the first done. ss_n[1] is never low during transfer 0.
- req=2'b11 held for 4 transfers -> grant sequence 01,10,01,10.
- req[0] pulsed for one cycle only -> a full 8-bit transfer runs and done pulses once; no second transfer.
- rst asserted after the 4th rising sclk -> next edge ss_n=2'b11, sclk=0, busy=0, rxData=0; no done pulse.
- SPI_MASTER_LOOPBACK_EN defined, txData=8'hA3, miso tied 0 -> rxData=8'hA3.
